// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the register-bus arbiter: FSM encodings, master indices
// and default bus widths.
package reg_bus_arbiter_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/reg_bus_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the master that did not own the last
// transaction wins.
module rr_arb2
    import reg_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        if (&req) begin
            gnt_idx = ~last_owner;
        end else begin
            gnt_idx = req[1] ? M1 : M0;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register-file port between two req/ack masters, one transaction at a
// time, with round-robin fairness (IDLE -> ISSUE -> WAIT -> DONE).
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_req,
    input  logic              i_m0_wr,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_wr,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_wr,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_busy,
    output logic              o_owner
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              mem_wr_q, mem_wr_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              gnt_valid;
    logic              gnt_idx;

    rr_arb2 u_rr_arb2 (
        .req        ({i_m1_req, i_m0_req}),
        .last_owner (last_owner_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_q         <= 1'b0;
            mem_wr_q     <= 1'b0;
            owner_q      <= M0;
            last_owner_q <= M1;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_q         <= wr_d;
            mem_wr_q     <= mem_wr_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    // Strobes (mem_wr, acks) default low so each is a single-cycle pulse.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        mem_wr_d     = 1'b0;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    owner_d      = gnt_idx;
                    last_owner_d = gnt_idx;
                    wr_d         = (gnt_idx == M1) ? i_m1_wr    : i_m0_wr;
                    addr_d       = (gnt_idx == M1) ? i_m1_addr  : i_m0_addr;
                    wdata_d      = (gnt_idx == M1) ? i_m1_wdata : i_m0_wdata;
                    mem_wr_d     = (gnt_idx == M1) ? i_m1_wr    : i_m0_wr;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!wr_q) begin
                    if (owner_q == M0) begin
                        rdata0_d = i_mem_data;
                    end else begin
                        rdata1_d = i_mem_data;
                    end
                end
                ack0_d  = (owner_q == M0);
                ack1_d  = (owner_q == M1);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_mem_addr = addr_q;
    assign o_mem_data = wdata_q;
    assign o_mem_wr   = mem_wr_q;
    assign o_m0_ack   = ack0_q;
    assign o_m1_ack   = ack1_q;
    assign o_m0_rdata = rdata0_q;
    assign o_m1_rdata = rdata1_q;
    assign o_owner    = owner_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: stimulus pushes expected acks (master,
// cycle, owner, read data); a negedge monitor pops and compares on every ack.
module tb_reg_bus_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam logic [AW-1:0] CH_MUX_ENABLE = 8'h10;
    localparam logic [AW-1:0] SEL           = 8'h11;
    localparam logic [AW-1:0] UNMAPPED      = 8'hF0;

    logic          i_clk, i_rst_n;
    logic          i_m0_req, i_m0_wr, i_m1_req, i_m1_wr;
    logic [AW-1:0] i_m0_addr, i_m1_addr, o_mem_addr;
    logic [DW-1:0] i_m0_wdata, i_m1_wdata, o_m0_rdata, o_m1_rdata;
    logic [DW-1:0] o_mem_data, i_mem_data;
    logic          o_m0_ack, o_m1_ack, o_mem_wr, o_busy, o_owner;

    reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_m0_req   (i_m0_req),
        .i_m0_wr    (i_m0_wr),
        .i_m0_addr  (i_m0_addr),
        .i_m0_wdata (i_m0_wdata),
        .o_m0_ack   (o_m0_ack),
        .o_m0_rdata (o_m0_rdata),
        .i_m1_req   (i_m1_req),
        .i_m1_wr    (i_m1_wr),
        .i_m1_addr  (i_m1_addr),
        .i_m1_wdata (i_m1_wdata),
        .o_m1_ack   (o_m1_ack),
        .o_m1_rdata (o_m1_rdata),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .o_mem_wr   (o_mem_wr),
        .i_mem_data (i_mem_data),
        .o_busy     (o_busy),
        .o_owner    (o_owner)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Register file model: 1-cycle registered read, 0x00..0x1F mapped, rest reads 0.
    logic [DW-1:0] mem [0:255] = '{default: '0};
    logic [DW-1:0] mem_rd = '0;
    always @(posedge i_clk) begin
        if (o_mem_wr) mem[o_mem_addr] <= o_mem_data;
        mem_rd <= (o_mem_addr < 8'h20) ? mem[o_mem_addr] : '0;
    end
    assign i_mem_data = mem_rd;
    wire [3:0] o_ch_ena = mem[CH_MUX_ENABLE][3:0];

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        bit          idx;
        bit          rd;
        logic [DW-1:0] rdata;
        int          at;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int last_wr_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (i_rst_n) begin
            if (o_mem_wr) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                chk("mem_wr_outside_busy", o_busy, 1'b1);
            end
            if (o_m0_ack || o_m1_ack) begin
                chk("acks_exclusive", {o_m0_ack, o_m1_ack} == 2'b11, 1'b0);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack actual=m%0d required=none (cyc %0d)",
                             o_m1_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_master", o_m1_ack, e.idx);
                    chk("ack_cycle", cyc, e.at);
                    chk("owner", o_owner, e.idx);
                    chk("busy_in_done", o_busy, 1'b1);
                    if (e.rd) chk("rdata", e.idx ? o_m1_rdata : o_m0_rdata, e.rdata);
                    $display("txn m%0d %s owner=%0d rdata0=%h rdata1=%h cyc=%0d",
                             e.idx, e.rd ? "rd" : "wr", o_owner, o_m0_rdata, o_m1_rdata, cyc);
                end
            end
        end
    end

    function automatic exp_t mk(input bit idx, input bit rd, input logic [DW-1:0] d, input int at);
        exp_t e;
        e.idx = idx; e.rd = rd; e.rdata = d; e.at = at;
        return e;
    endfunction

    task automatic do_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Hold each request until it has collected n acks, then drop it.
    task automatic run(input int n0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input int n1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int got0 = 0;
        int got1 = 0;
        i_m0_req = (n0 > 0); i_m0_wr = w0; i_m0_addr = a0; i_m0_wdata = d0;
        i_m1_req = (n1 > 0); i_m1_wr = w1; i_m1_addr = a1; i_m1_wdata = d1;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (i_m0_req && o_m0_ack) begin got0++; if (got0 >= n0) i_m0_req = 1'b0; end
            if (i_m1_req && o_m1_ack) begin got1++; if (got1 >= n1) i_m1_req = 1'b0; end
            if (!i_m0_req && !i_m1_req) break;
        end
        chk("run_timeout", {i_m0_req, i_m1_req}, 2'b00);
        i_m0_req = 1'b0; i_m1_req = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    int c, w0;

    initial begin
        i_rst_n = 1'b0;
        i_m0_req = 0; i_m0_wr = 0; i_m0_addr = '0; i_m0_wdata = '0;
        i_m1_req = 0; i_m1_wr = 0; i_m1_addr = '0; i_m1_wdata = '0;
        #1;
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_owner", o_owner, 1'b0);
        chk("reset_mem_addr", o_mem_addr, '0);
        chk("reset_rdata0", o_m0_rdata, '0);
        do_reset();

        // 1: m0 write CH_MUX_ENABLE = 5
        @(negedge i_clk); c = cyc; w0 = wr_cnt;
        sb.push_back(mk(0, 0, '0, c + 3));
        run(1, 1, CH_MUX_ENABLE, 16'h0005, 0, 0, '0, '0);
        chk("t1_wr_pulses", wr_cnt - w0, 1);
        chk("t1_wr_in_issue", last_wr_cyc, c + 1);
        chk("t1_ch_ena", o_ch_ena, 4'h5);
        chk("t1_hold_addr", o_mem_addr, CH_MUX_ENABLE);
        chk("t1_hold_data", o_mem_data, 16'h0005);

        // 2: m1 read CH_MUX_ENABLE
        @(negedge i_clk); c = cyc; w0 = wr_cnt;
        sb.push_back(mk(1, 1, 16'h0005, c + 3));
        run(0, 0, '0, '0, 1, 0, CH_MUX_ENABLE, '0);
        chk("t2_no_wr", wr_cnt - w0, 0);
        chk("t2_m0_rdata_untouched", o_m0_rdata, '0);

        // 3: after reset, tie -> m0 write SEL=3 first, then m1 read SEL; third tie to m0
        do_reset();
        @(negedge i_clk); c = cyc;
        sb.push_back(mk(0, 0, '0, c + 3));
        sb.push_back(mk(1, 1, 16'h0003, c + 7));
        run(1, 1, SEL, 16'h0003, 1, 0, SEL, '0);
        @(negedge i_clk); c = cyc;
        sb.push_back(mk(0, 1, 16'h0003, c + 3));
        sb.push_back(mk(1, 1, 16'h0005, c + 7));
        run(1, 0, SEL, '0, 1, 0, CH_MUX_ENABLE, '0);

        // 4: both held for five transactions -> 0,1,0,1,0 every 4 cycles
        @(negedge i_clk); c = cyc;
        sb.push_back(mk(0, 1, 16'h0005, c + 3));
        sb.push_back(mk(1, 1, 16'h0003, c + 7));
        sb.push_back(mk(0, 1, 16'h0005, c + 11));
        sb.push_back(mk(1, 1, 16'h0003, c + 15));
        sb.push_back(mk(0, 1, 16'h0005, c + 19));
        run(3, 0, CH_MUX_ENABLE, '0, 2, 0, SEL, '0);

        // 5: async reset during WAIT of an m1 read
        @(negedge i_clk);
        i_m1_req = 1'b1; i_m1_wr = 1'b0; i_m1_addr = SEL;
        repeat (2) @(negedge i_clk);
        chk("t5_busy_in_wait", o_busy, 1'b1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("t5_busy_cleared", o_busy, 1'b0);
        chk("t5_acks_cleared", {o_m0_ack, o_m1_ack}, 2'b00);
        chk("t5_mem_wr_cleared", o_mem_wr, 1'b0);
        chk("t5_m1_rdata_reset", o_m1_rdata, '0);
        i_m1_req = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (6) @(negedge i_clk);
        @(negedge i_clk); c = cyc;
        sb.push_back(mk(0, 1, 16'h0005, c + 3));
        sb.push_back(mk(1, 1, 16'h0003, c + 7));
        run(1, 0, CH_MUX_ENABLE, '0, 1, 0, SEL, '0);

        // 6: m0 reads unmapped address and drops req right after grant
        @(negedge i_clk); c = cyc;
        sb.push_back(mk(0, 1, 16'h0000, c + 3));
        i_m0_req = 1'b1; i_m0_wr = 1'b0; i_m0_addr = UNMAPPED;
        @(negedge i_clk);
        i_m0_req = 1'b0;
        repeat (8) @(negedge i_clk);
        chk("t6_m0_rdata_unmapped", o_m0_rdata, '0);
        chk("t6_m1_rdata_untouched", o_m1_rdata, 16'h0003);
        chk("t6_idle", o_busy, 1'b0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
